// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Looks up the fetch PC, tracks predictions down to MEM, then resolves them and updates the table.
module branch_predictor_btb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_F,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  pre_branch,
  output logic                  prediction,
  output logic [DATA_WIDTH-1:0] label,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_pc,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  output logic                  error,
  output logic                  correct,
  output logic [DATA_WIDTH-1:0] new_label,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX   = {CTR_BITS{1'b1}};

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_r;
  logic [TAG_W-1:0] tag_f, tag_r;
  logic             hit_f, hit_r;

  logic                  hit_d, pt_d, hit_e, pt_e, hit_m, pt_m;
  logic [DATA_WIDTH-1:0] tgt_d, tgt_e, tgt_m;
  logic                  mis_m, alias_m;
  logic                  unused_bits;

  // Fetch-side lookup; reads pre-update contents, no bypass from resolution.
  assign idx_f      = pc_F[IDX_W+1:2];
  assign tag_f      = pc_F[DATA_WIDTH-1:IDX_W+2];
  assign hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pre_branch = hit_f;
  assign prediction = hit_f & ctr_q[idx_f][CTR_BITS-1];
  assign label      = hit_f ? target_q[idx_f] : '0;

  assign idx_r = res_pc[IDX_W+1:2];
  assign tag_r = res_pc[DATA_WIDTH-1:IDX_W+2];
  assign hit_r = valid_q[idx_r] && (tag_q[idx_r] == tag_r);

  // Hit flag travels with the metadata but resolution only needs direction and target.
  assign unused_bits = ^{pc_F[1:0], res_pc[1:0], hit_m};

  // Prediction metadata follows the datapath's F/D/E/M stall and flush rules.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {hit_d, pt_d, tgt_d} <= '0;
      {hit_e, pt_e, tgt_e} <= '0;
      {hit_m, pt_m, tgt_m} <= '0;
    end else begin
      if (flush)       {hit_d, pt_d, tgt_d} <= '0;
      else if (!stall) {hit_d, pt_d, tgt_d} <= {hit_f, prediction, label};
      if (flush || stall) {hit_e, pt_e, tgt_e} <= '0;
      else                {hit_e, pt_e, tgt_e} <= {hit_d, pt_d, tgt_d};
      if (flush) {hit_m, pt_m, tgt_m} <= '0;
      else       {hit_m, pt_m, tgt_m} <= {hit_e, pt_e, tgt_e};
    end
  end

  assign mis_m     = res_valid & ((pt_m != res_taken) | (pt_m & res_taken & (tgt_m != res_target)));
  assign alias_m   = ~res_valid & pt_m;
  assign error     = mis_m | alias_m;
  assign correct   = res_valid & pt_m & res_taken & (tgt_m == res_target);
  assign new_label = (res_valid & res_taken) ? res_target : res_pc + DATA_WIDTH'(4);

  // Table update from the resolving instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[IDX_W'(i)]    <= '0;
        target_q[IDX_W'(i)] <= '0;
        ctr_q[IDX_W'(i)]    <= CTR_RST;
      end
    end else if (res_valid && res_taken) begin
      target_q[idx_r] <= res_target;
      if (hit_r) begin
        if (ctr_q[idx_r] != CTR_MAX) ctr_q[idx_r] <= ctr_q[idx_r] + CTR_BITS'(1);
      end else begin
        valid_q[idx_r] <= 1'b1;
        tag_q[idx_r]   <= tag_r;
        ctr_q[idx_r]   <= CTR_ALLOC;
      end
    end else if (res_valid && hit_r) begin
      if (ctr_q[idx_r] != '0) ctr_q[idx_r] <= ctr_q[idx_r] - CTR_BITS'(1);
    end else if (alias_m) begin
      valid_q[idx_r] <= 1'b0;
    end
  end

  // Performance counters, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_valid) branch_cnt  <= branch_cnt + CNT_WIDTH'(1);
      if (error)     mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: per-cycle vector table plus a mid-stream reset sequence.
module tb_branch_predictor_btb;

  logic        clk, rst;
  logic [31:0] pc_F, res_pc, res_target;
  logic        stall, flush, res_valid, res_taken;
  logic        pre_branch, prediction, error, correct;
  logic [31:0] label, new_label, branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_predictor_btb dut (
    .clk(clk), .rst(rst), .pc_F(pc_F), .stall(stall), .flush(flush),
    .pre_branch(pre_branch), .prediction(prediction), .label(label),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .error(error), .correct(correct), .new_label(new_label),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        st, fl, rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        pre, pred;
    logic [31:0] lbl;
    logic        err, cor;
    logic [31:0] nl;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] pc, input logic st, input logic fl, input logic rv,
                              input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                              input logic pre, input logic pred, input logic [31:0] lbl,
                              input logic err, input logic cor, input logic [31:0] nl);
    vec_t v;
    v.pc = pc; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt;
    v.pre = pre; v.pred = pred; v.lbl = lbl; v.err = err; v.cor = cor; v.nl = nl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    // pc, st, fl, rv, rpc, rt, rtgt | pre, pred, label, err, cor, new_label
    vecs[0]  = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[1]  = mk(32'h208, 0, 0, 1, 32'h100, 1, 32'h80,  0, 0, 32'h0,   1, 0, 32'h80);
    vecs[2]  = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 0, 32'h4);
    vecs[3]  = mk(32'h208, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[4]  = mk(32'h208, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[5]  = mk(32'h208, 0, 0, 1, 32'h100, 1, 32'h80,  0, 0, 32'h0,   0, 1, 32'h80);
    vecs[6]  = mk(32'h100, 0, 0, 1, 32'h100, 0, 32'h0,   1, 1, 32'h80,  0, 0, 32'h104);
    vecs[7]  = mk(32'h208, 0, 0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[8]  = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h80,  0, 0, 32'h4);
    vecs[9]  = mk(32'h208, 0, 0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h104);
    vecs[10] = mk(32'h208, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[11] = mk(32'h208, 0, 0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[12] = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h80,  0, 0, 32'h4);
    vecs[13] = mk(32'h400, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[14] = mk(32'h208, 0, 0, 1, 32'h140, 1, 32'h300, 0, 0, 32'h0,   1, 0, 32'h300);
    vecs[15] = mk(32'h140, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h4);
    vecs[16] = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[17] = mk(32'h208, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[18] = mk(32'h208, 0, 0, 0, 32'h140, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h144);
    vecs[19] = mk(32'h140, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[20] = mk(32'h208, 0, 0, 1, 32'h100, 1, 32'h80,  0, 0, 32'h0,   1, 0, 32'h80);
    vecs[21] = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 0, 32'h4);
    vecs[22] = mk(32'h208, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h4);
    vecs[23] = mk(32'h208, 0, 0, 0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[24] = mk(32'h208, 0, 0, 0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[25] = mk(32'h208, 0, 0, 1, 32'h100, 1, 32'h80,  0, 0, 32'h0,   0, 1, 32'h80);
    vecs[26] = mk(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 0, 32'h4);
    vecs[27] = mk(32'h100, 0, 1, 0, 32'h100, 0, 32'h0,   1, 1, 32'h80,  0, 0, 32'h104);
    vecs[28] = mk(32'h208, 0, 0, 0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[29] = mk(32'h208, 0, 0, 0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);
    vecs[30] = mk(32'h208, 0, 0, 0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104);

    rst = 1'b0; pc_F = 32'h100; stall = 0; flush = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
    #1;
    chk("rst pre_branch", 32'(pre_branch), 32'h0);
    chk("rst prediction", 32'(prediction), 32'h0);
    chk("rst label", label, 32'h0);
    chk("rst error", 32'(error), 32'h0);
    chk("rst correct", 32'(correct), 32'h0);
    chk("rst new_label", new_label, 32'h4);
    chk("rst branch_cnt", branch_cnt, 32'h0);
    chk("rst mispred_cnt", mispred_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      pc_F = vecs[i].pc; stall = vecs[i].st; flush = vecs[i].fl;
      res_valid = vecs[i].rv; res_pc = vecs[i].rpc; res_taken = vecs[i].rt; res_target = vecs[i].rtgt;
      @(negedge clk);
      chk($sformatf("r%0d pre_branch", i), 32'(pre_branch), 32'(vecs[i].pre));
      chk($sformatf("r%0d prediction", i), 32'(prediction), 32'(vecs[i].pred));
      chk($sformatf("r%0d label", i), label, vecs[i].lbl);
      chk($sformatf("r%0d error", i), 32'(error), 32'(vecs[i].err));
      chk($sformatf("r%0d correct", i), 32'(correct), 32'(vecs[i].cor));
      chk($sformatf("r%0d new_label", i), new_label, vecs[i].nl);
      @(posedge clk);
      #1;
    end
    chk("branch_cnt after table", branch_cnt, 32'd9);
    chk("mispred_cnt after table", mispred_cnt, 32'd5);

    // Mid-cycle asynchronous reset with a pending taken update to the live entry.
    pc_F = 32'h100; res_valid = 0; res_pc = 0;
    #1;
    chk("pre-reset hit", 32'(pre_branch), 32'h1);
    res_valid = 1; res_pc = 32'h100; res_taken = 1; res_target = 32'h500;
    #1 rst = 1'b0;
    #1;
    chk("async rst pre_branch", 32'(pre_branch), 32'h0);
    chk("async rst prediction", 32'(prediction), 32'h0);
    chk("async rst label", label, 32'h0);
    chk("async rst correct", 32'(correct), 32'h0);
    chk("async rst branch_cnt", branch_cnt, 32'h0);
    chk("async rst mispred_cnt", mispred_cnt, 32'h0);
    @(posedge clk);
    #1;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
    #1;
    chk("in rst error", 32'(error), 32'h0);
    chk("in rst new_label", new_label, 32'h4);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post rst pre_branch", 32'(pre_branch), 32'h0);
    chk("post rst label", label, 32'h0);
    @(posedge clk);
    #1;
    chk("post rst branch_cnt", branch_cnt, 32'h0);
    chk("post rst mispred_cnt", mispred_cnt, 32'h0);
    chk("post rst lookup", 32'(pre_branch), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
